slave_bit_timer: RTL and testbench

// - Bit/byte timing stage for the I2C slave; sits directly upstream of the slave main controller FSM.
// - Watches synchronized SCL and start/stop detector outputs, and counts bits within each 9-clock frame (8 data + ACK).
// - Emits the single-cycle strobes the controller sequences on: byte_received, ack_prep, ack_check, ack_done.
// - Emits the shift strobes for the RX and TX shift registers.

---
 rtl/slave_bit_timer.sv | 165 ++++++++++++++++
 tb/tb_slave_bit_timer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_bit_timer.sv
// slave_bit_timer
// Bit/byte timing stage of the I2C slave. Counts SCL clocks inside each
// 9-clock frame (8 data bits + ACK) and issues single-cycle strobes for the
// controller FSM and the RX/TX shift registers.
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   SCL_sync              synchronized SCL
//   start, stop           1-clk START/repeated-START and STOP pulses
//   rx_enable, tx_enable  shifting permissions from the controller
//   rx_sample, tx_shift   shift register strobes
//   byte_received, ack_prep, ack_check, ack_done  controller strobes
//   bit_count             bit index 0..8 (8 = ACK slot)
module slave_bit_timer #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       SCL_sync,
    input  logic       start,
    input  logic       stop,
    input  logic       rx_enable,
    input  logic       tx_enable,
    output logic       rx_sample,
    output logic       tx_shift,
    output logic       byte_received,
    output logic       ack_prep,
    output logic       ack_check,
    output logic       ack_done,
    output logic [3:0] bit_count
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned BC_W  = 4;
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
    localparam bit NO_HOLD = (HOLD_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [BC_W-1:0]   bc_n;
    logic [CNT_W-1:0]  hold_cnt, hold_n;
    logic              fall_pend, fall_pend_n;
    logic              rise_pend, rise_pend_n;
    logic              scl_q;
    logic              rx_sample_n, tx_shift_n, byte_received_n;
    logic              ack_prep_n, ack_check_n, ack_done_n;
    logic              rise, fall, fall_ev, rise_ev;

    assign rise = SCL_sync & ~scl_q;
    assign fall = ~SCL_sync & scl_q;

    // State, counters and registered strobes
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            bit_count     <= '0;
            hold_cnt      <= '0;
            fall_pend     <= 1'b0;
            rise_pend     <= 1'b0;
            scl_q         <= 1'b1;
            rx_sample     <= 1'b0;
            tx_shift      <= 1'b0;
            byte_received <= 1'b0;
            ack_prep      <= 1'b0;
            ack_check     <= 1'b0;
            ack_done      <= 1'b0;
        end else begin
            state         <= state_n;
            bit_count     <= bc_n;
            hold_cnt      <= hold_n;
            fall_pend     <= fall_pend_n;
            rise_pend     <= rise_pend_n;
            scl_q         <= SCL_sync;
            rx_sample     <= rx_sample_n;
            tx_shift      <= tx_shift_n;
            byte_received <= byte_received_n;
            ack_prep      <= ack_prep_n;
            ack_check     <= ack_check_n;
            ack_done      <= ack_done_n;
        end
    end

    // Next-state, hold sequencing and strobe generation
    always_comb begin
        state_n         = state;
        bc_n            = bit_count;
        hold_n          = hold_cnt;
        fall_pend_n     = fall_pend;
        rise_pend_n     = 1'b0;
        rx_sample_n     = 1'b0;
        tx_shift_n      = 1'b0;
        byte_received_n = 1'b0;
        ack_prep_n      = 1'b0;
        ack_check_n     = 1'b0;
        ack_done_n      = 1'b0;
        fall_ev         = 1'b0;
        rise_ev         = 1'b0;

        if (start) begin
            state_n     = DATA;
            bc_n        = '0;
            fall_pend_n = 1'b0;
            hold_n      = '0;
        end else if (stop) begin
            state_n     = IDLE;
            bc_n        = '0;
            fall_pend_n = 1'b0;
            hold_n      = '0;
        end else if (state == IDLE) begin
            fall_pend_n = 1'b0;
            hold_n      = '0;
        end else begin
            // A rise flushes a pending fall now and defers its own strobe a cycle
            if (fall_pend && (rise || hold_cnt <= CNT_W'(1))) begin
                fall_ev     = 1'b1;
                fall_pend_n = 1'b0;
                hold_n      = '0;
            end else if (fall_pend) begin
                hold_n = hold_cnt - CNT_W'(1);
            end
            rise_ev     = (rise && !fall_pend) || rise_pend;
            rise_pend_n = rise && fall_pend;

            if (fall) begin
                if (NO_HOLD && !rise_pend) begin
                    fall_ev = 1'b1;
                end else begin
                    // Never let a fresh fall strobe collide with a deferred rise
                    fall_pend_n = 1'b1;
                    hold_n      = NO_HOLD ? CNT_W'(1) : HOLD_LD;
                end
            end

            if (fall_ev) begin
                if (state == DATA) begin
                    if (bit_count == BC_W'(8)) begin
                        ack_prep_n = 1'b1;
                        state_n    = ACK;
                    end else if (bit_count != '0) begin
                        tx_shift_n = tx_enable;
                    end
                end else begin
                    ack_done_n = 1'b1;
                    bc_n       = '0;
                    state_n    = DATA;
                end
            end else if (rise_ev) begin
                if (state == DATA) begin
                    rx_sample_n = rx_enable;
                    if (bit_count < BC_W'(8)) begin
                        bc_n = bit_count + BC_W'(1);
                    end
                    byte_received_n = (bit_count == BC_W'(7));
                end else begin
                    ack_check_n = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_slave_bit_timer.sv
// tb_slave_bit_timer
// Drives two slave_bit_timer instances (HOLD_CYCLES 2 and 4) with the same
// directed SCL/start/stop sequences and checks every cycle against an
// event-time model, plus hand-computed pulse counts and strobe latencies.
module tb_slave_bit_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic rx_en = 1'b0;
    logic tx_en = 1'b0;

    logic       rx0, tx0, br0, ap0, ac0, ad0;
    logic [3:0] bc0;
    logic       rx1, tx1, br1, ap1, ac1, ad1;
    logic [3:0] bc1;

    always #5 clk = ~clk;

    slave_bit_timer #(.HOLD_CYCLES(2)) dut (
        .clk(clk), .n_rst(rst_n), .SCL_sync(scl), .start(start), .stop(stop),
        .rx_enable(rx_en), .tx_enable(tx_en),
        .rx_sample(rx0), .tx_shift(tx0), .byte_received(br0),
        .ack_prep(ap0), .ack_check(ac0), .ack_done(ad0), .bit_count(bc0)
    );

    slave_bit_timer #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .n_rst(rst_n), .SCL_sync(scl), .start(start), .stop(stop),
        .rx_enable(rx_en), .tx_enable(tx_en),
        .rx_sample(rx1), .tx_shift(tx1), .byte_received(br1),
        .ack_prep(ap1), .ack_check(ac1), .ack_done(ad1), .bit_count(bc1)
    );

    int total = 0;
    int bad = 0;

    // Model state per instance: frame position and absolute due cycles of strobes
    int        cyc = 0;
    int        m_state [2];   // 0 idle, 1 data bits, 2 ack slot
    int        m_bc    [2];
    bit        m_prev  [2];
    int        fall_due[2];
    int        rise_due[2];
    logic [9:0] expv   [2];   // {rx, tx, br, ap, ac, ad, bc[3:0]}

    function automatic int hold_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_bc[i] = 0; m_prev[i] = 1'b1;
            fall_due[i] = -1; rise_due[i] = -1; expv[i] = '0;
        end
    endtask

    task automatic model_step(input int i, input int c);
        bit r, f;
        bit [5:0] s;
        r = scl & ~m_prev[i];
        f = ~scl & m_prev[i];
        m_prev[i] = scl;
        s = '0;
        if (start) begin
            m_state[i] = 1; m_bc[i] = 0; fall_due[i] = -1; rise_due[i] = -1;
        end else if (stop) begin
            m_state[i] = 0; m_bc[i] = 0; fall_due[i] = -1; rise_due[i] = -1;
        end else if (m_state[i] == 0) begin
            fall_due[i] = -1; rise_due[i] = -1;
        end else begin
            if (f) fall_due[i] = (hold_of(i) == 0 && rise_due[i] == c + 1) ? c + 2 : c + 1 + hold_of(i);
            if (r) begin
                if (fall_due[i] >= 0) begin fall_due[i] = c + 1; rise_due[i] = c + 2; end
                else rise_due[i] = c + 1;
            end
            if (fall_due[i] == c + 1) begin
                fall_due[i] = -1;
                if (m_state[i] == 1) begin
                    if (m_bc[i] == 8) begin s[2] = 1'b1; m_state[i] = 2; end
                    else if (m_bc[i] >= 1) s[4] = tx_en;
                end else begin
                    s[0] = 1'b1; m_bc[i] = 0; m_state[i] = 1;
                end
            end else if (rise_due[i] == c + 1) begin
                rise_due[i] = -1;
                if (m_state[i] == 1) begin
                    s[5] = rx_en;
                    if (m_bc[i] < 8) begin
                        m_bc[i] = m_bc[i] + 1;
                        if (m_bc[i] == 8) s[3] = 1'b1;
                    end
                end else begin
                    s[1] = 1'b1;
                end
            end
        end
        expv[i] = {s, 4'(m_bc[i])};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else for (int i = 0; i < 2; i++) model_step(i, cyc);
            if (clk) cyc = cyc + 1;
        end
    end

    // Pulse statistics for literal checks
    int rx_cnt, tx_cnt, br_cnt, ap_cnt, ac_cnt, ad_cnt;
    int ap_cyc, ad_cyc, ap1_cyc, ac1_cyc;

    task automatic clear_counts();
        rx_cnt = 0; tx_cnt = 0; br_cnt = 0; ap_cnt = 0; ac_cnt = 0; ad_cnt = 0;
        ap_cyc = -1; ad_cyc = -1; ap1_cyc = -1; ac1_cyc = -1;
    endtask

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        logic [9:0] act [2];
        forever begin
            @(negedge clk);
            act[0] = {rx0, tx0, br0, ap0, ac0, ad0, bc0};
            act[1] = {rx1, tx1, br1, ap1, ac1, ad1, bc1};
            for (int i = 0; i < 2; i++) begin
                total++;
                if (act[i] !== expv[i]) begin
                    bad++;
                    $display("FAIL cycle_compare inst=%0d cyc=%0d got=%b want=%b", i, cyc, act[i], expv[i]);
                end
            end
            if (rst_n) begin
                rx_cnt += int'(rx0); tx_cnt += int'(tx0); br_cnt += int'(br0);
                ap_cnt += int'(ap0); ac_cnt += int'(ac0); ad_cnt += int'(ad0);
                if (ap0) ap_cyc = cyc;
                if (ad0) ad_cyc = cyc;
                if (ap1) ap1_cyc = cyc;
                if (ac1) ac1_cyc = cyc;
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0; tick();
        scl = 1'b0; repeat (6) tick();
    endtask

    task automatic do_stop();
        scl = 1'b1; tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0; tick();
    endtask

    // One SCL clock: high then low; returns the cycle the fall is detected in
    task automatic pulse(input int hi, input int lo, output int fall_cyc);
        scl = 1'b1; repeat (hi) tick();
        scl = 1'b0; fall_cyc = cyc; repeat (lo) tick();
    endtask

    initial begin
        int fc, f8, rc;
        clear_counts();
        repeat (3) tick();
        rst_n = 1'b1;
        tick(); tick();
        check("reset_bit_count", int'(bc0), 0);

        // Full receive byte with ACK
        rx_en = 1'b1; clear_counts();
        do_start();
        for (int k = 0; k < 9; k++) begin
            pulse(4, 6, fc);
            if (k == 7) f8 = fc;
        end
        check("rx_sample_count", rx_cnt, 8);
        check("byte_received_count", br_cnt, 1);
        check("ack_prep_latency", ap_cyc - f8, 3);
        check("ack_check_count", ac_cnt, 1);
        check("ack_done_latency", ad_cyc - fc, 3);
        check("bit_count_after_ack", int'(bc0), 0);
        do_stop();

        // Transmit byte
        rx_en = 1'b0; tx_en = 1'b1; clear_counts();
        do_start();
        for (int k = 0; k < 9; k++) pulse(4, 6, fc);
        check("tx_shift_count", tx_cnt, 7);
        check("rx_sample_never", rx_cnt, 0);
        do_stop();

        // Repeated start at bit 5
        rx_en = 1'b1; tx_en = 1'b0; clear_counts();
        do_start();
        for (int k = 0; k < 5; k++) pulse(4, 6, fc);
        check("bit_count_before_rstart", int'(bc0), 5);
        start = 1'b1; tick(); start = 1'b0; tick();
        check("bit_count_after_rstart", int'(bc0), 0);
        check("no_byte_after_rstart", br_cnt, 0);
        for (int k = 0; k < 8; k++) pulse(4, 6, fc);
        check("byte_after_rstart", br_cnt, 1);
        pulse(4, 6, fc);
        do_stop();

        // Stop in ACK slot while ack_done is pending
        clear_counts();
        do_start();
        for (int k = 0; k < 8; k++) pulse(4, 6, fc);
        scl = 1'b1; repeat (3) tick();
        check("ack_check_before_stop", ac_cnt, 1);
        scl = 1'b0; tick();
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (8) tick();
        check("no_ack_done_after_stop", ad_cnt, 0);
        clear_counts();
        for (int k = 0; k < 3; k++) pulse(3, 3, fc);
        check("idle_no_strobes", rx_cnt + tx_cnt + br_cnt + ap_cnt + ac_cnt + ad_cnt, 0);

        // Short SCL low after bit 8 flushes pending ack_prep (HOLD 4 instance)
        clear_counts();
        do_start();
        for (int k = 0; k < 7; k++) pulse(4, 6, fc);
        scl = 1'b1; repeat (4) tick();
        scl = 1'b0; tick(); tick();
        scl = 1'b1; rc = cyc; repeat (4) tick();
        check("hold4_ack_prep_after_rise", ap1_cyc - rc, 1);
        check("hold4_ack_check_next", ac1_cyc - rc, 2);
        scl = 1'b0; repeat (8) tick();
        do_stop();

        // Async reset in the middle of bit 7
        clear_counts();
        do_start();
        for (int k = 0; k < 6; k++) pulse(4, 6, fc);
        check("bit_count_before_reset", int'(bc0), 6);
        @(negedge clk);
        scl = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_bit_count", int'(bc0), 0);
        check("async_reset_strobes", int'({rx0, tx0, br0, ap0, ac0, ad0}), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        clear_counts();
        for (int k = 0; k < 3; k++) pulse(3, 5, fc);
        check("post_reset_ignored", rx_cnt + tx_cnt + br_cnt + ap_cnt + ac_cnt + ad_cnt, 0);
        check("post_reset_bit_count", int'(bc0), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
